// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
//
// Connects the keypad scanner to the processor input port. It follows the
// same pattern as the UART RX path: data, data-present and a read-ack pulse.
//
// Signals:
//   key_code     [7:0]  head of the key event queue, 8'h00 when empty
//   key_present         queue not empty
//   read_key_ack        one-cycle pulse from the reader; pops the head
//   key_down            debounced state is exactly one key held
//   overflow            sticky; a press event was dropped on a full queue
//
// Modports:
//   master  the scanner (drives key data, receives the ack)
//   slave   the reader (receives key data, drives the ack)
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
  logic [7:0] key_code;
  logic       key_present;
  logic       read_key_ack;
  logic       key_down;
  logic       overflow;

  modport master (
    output key_code,
    output key_present,
    output key_down,
    output overflow,
    input  read_key_ack
  );

  modport slave (
    input  key_code,
    input  key_present,
    input  key_down,
    input  overflow,
    output read_key_ack
  );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Active 4x4 keypad scanner. It drives one column low at a time and samples
// the rows. Whole 16-key scans are debounced and encoded to a key number.
// Each new single-key press is queued in a small FIFO that the processor
// reads through keypad_scanner_if.
//
// Parameters:
//   SCAN_DIV        clk cycles each column is driven (must be >= 4 so the
//                   synchronized row settles before it is sampled)
//   DEBOUNCE_SCANS  identical consecutive scans needed to accept a new
//                   state (1..15)
//   FIFO_DEPTH      key event queue depth (power of 2, >= 2)
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   col    column drive, active-low one-hot
//   row    row sense, active-low, asynchronous to clk
//   kp     keypad_scanner_if.master (key_code, key_present, read_key_ack,
//          key_down, overflow)
//
// Optional build macro:
//   KEYPAD_ASCII_EN  when defined, key_code carries the ASCII character of
//                    the key number ('0'-'9', 'A'-'F') instead of {4'h0, n}.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [3:0]        col,
  input  logic [3:0]        row,
  keypad_scanner_if.master  kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_MAX   = 4'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  // Classification of a full scan. The key number is only meaningful for
  // CAND_KEY and is held at zero otherwise so whole-struct compares work.
  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_KEY   = 2'd1,
    CAND_MULTI = 2'd2
  } cand_kind_e;

  typedef struct packed {
    cand_kind_e kind;
    logic [3:0] num;
  } cand_t;

  localparam cand_t CAND_IDLE = '{kind: CAND_NONE, num: 4'd0};

  // Maps a key number to the byte presented on key_code.
  function automatic logic [7:0] encode_key(input logic [3:0] n);
`ifdef KEYPAD_ASCII_EN
    if (n < 4'd10) encode_key = 8'h30 + {4'h0, n};
    else           encode_key = 8'h41 + {4'h0, n} - 8'd10;
`else
    encode_key = {4'h0, n};
`endif
  endfunction

  // Row synchronizer
  logic [3:0] row_meta_q, row_meta_d;
  logic [3:0] row_sync_q, row_sync_d;

  // Column scan
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [15:0]      snapshot_q, snapshot_d;
  logic             tick;
  logic             scan_done;

  // Scan classification
  cand_t      cand_now;
  logic [4:0] zero_cnt;
  logic [3:0] zero_idx;

  // Debounce
  cand_t      cand_q, cand_d;
  cand_t      deb_q, deb_d;
  logic [3:0] stable_q, stable_d;
  logic [3:0] stable_next;
  logic       push_q, push_d;
  logic [3:0] push_num_q, push_num_d;

  // Event FIFO
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_present_q, key_present_d;
  logic             pop_ok;
  logic             push_ok;

  // The row lines come straight from mechanical switches, so they pass
  // through two flops before anything looks at them.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
    end
  end

  // Prescaler and column stepping. The row nibble is captured at the very
  // end of each column slot, so it has had the whole slot to settle through
  // the synchronizer.
  always_comb begin
    div_d      = div_q;
    col_idx_d  = col_idx_q;
    snapshot_d = snapshot_q;
    tick       = (div_q == DIV_LAST);
    if (tick) begin
      div_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      snapshot_d[int'(col_idx_q)*4 +: 4] = row_sync_q;
    end else begin
      div_d = div_q + 1'b1;
    end
    scan_done = tick && (col_idx_q == 2'd3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      col_idx_q  <= '0;
      snapshot_q <= '1;
    end else begin
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      snapshot_q <= snapshot_d;
    end
  end

  assign col = ~(4'b0001 << col_idx_q);

  // Classifies the scan that is finishing. It reads snapshot_d so the last
  // column, captured on this same tick, is already included. A zero at bit
  // n is key n = 4*column + row.
  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snapshot_d[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_idx = 4'(i);
      end
    end
    cand_now = CAND_IDLE;
    if (zero_cnt == 5'd1) begin
      cand_now.kind = CAND_KEY;
      cand_now.num  = zero_idx;
    end else if (zero_cnt > 5'd1) begin
      cand_now.kind = CAND_MULTI;
    end
  end

  // Debounce over whole scans. A new state is accepted once it has been seen
  // DEBOUNCE_SCANS times in a row. Only an idle-to-single-key transition
  // produces a press event, so chords, roll-overs and releases never queue
  // anything and a held key is reported once.
  always_comb begin
    cand_d      = cand_q;
    deb_d       = deb_q;
    stable_d    = stable_q;
    stable_next = stable_q;
    push_d      = 1'b0;
    push_num_d  = push_num_q;
    if (scan_done) begin
      if (cand_now == cand_q) begin
        stable_next = (stable_q >= DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
      end else begin
        stable_next = 4'd1;
      end
      cand_d   = cand_now;
      stable_d = stable_next;
      if ((stable_next == DEB_MAX) && (cand_now != deb_q)) begin
        deb_d = cand_now;
        if ((deb_q.kind == CAND_NONE) && (cand_now.kind == CAND_KEY)) begin
          push_d     = 1'b1;
          push_num_d = cand_now.num;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q     <= CAND_IDLE;
      deb_q      <= CAND_IDLE;
      stable_q   <= '0;
      push_q     <= 1'b0;
      push_num_q <= '0;
    end else begin
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      stable_q   <= stable_d;
      push_q     <= push_d;
      push_num_q <= push_num_d;
    end
  end

  // Event FIFO. A pop is honoured only when something is stored, which is
  // judged before this cycle's push, so a simultaneous push into an empty
  // queue survives. A pop on a full queue frees the slot for a simultaneous
  // push, so only a push on a full queue without a pop is dropped.
  // key_code/key_present are registered copies of the head and occupancy.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    pop_ok        = kp.read_key_ack && (count_q != '0);
    push_ok       = push_q && ((count_q != FIFO_FULL) || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_num_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_q && !push_ok) begin
      overflow_d = 1'b1;
    end
    key_present_d = (count_q != '0);
    key_code_d    = (count_q != '0) ? encode_key(mem_q[rd_ptr_q]) : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      key_code_q    <= 8'h00;
      key_present_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      key_code_q    <= key_code_d;
      key_present_q <= key_present_d;
    end
  end

  assign kp.key_code    = key_code_q;
  assign kp.key_present = key_present_q;
  assign kp.key_down    = (deb_q.kind == CAND_KEY);
  assign kp.overflow    = overflow_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Active 4x4 keypad scanner that owns the column-drive side of the keypad matrix. It strobes one column at a time and samples the rows. Keys are debounced over whole scans and encoded to a 4-bit key number. Press events are queued in a small FIFO that PicoBlaze reads through an input port with a read-acknowledge pulse, in the same way as the UART RX path (data, data-present, ack).

Parameters:
SCAN_DIV, 100000, clk cycles each column is driven (1 kHz/column at 100 MHz); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a new debounced state; range 1..15
FIFO_DEPTH, 4, key event queue depth; power of 2, >= 2

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
col  out  4  column drive, active-low one-hot
row  in  4  row sense, active-low, asynchronous to clk
key_code  out  8  FIFO head: key number (or ASCII, see Optional Feature); 8'h00 when empty
key_present  out  1  FIFO not empty
read_key_ack  in  1  one-cycle pulse; pops FIFO head
key_down  out  1  debounced state is exactly one key held
overflow  out  1  sticky; a press event was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-low. Only clk is used. Reset values:
  - col=4'b1110, column index 0, prescaler 0
  - snapshot all-ones, candidate NONE, stable count 0, debounced NONE
  - FIFO empty, key_code=0, key_present=0, key_down=0, overflow=0
- row passes through a 2-flop synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1. At terminal count (tick):
  - capture the synchronized row into snapshot bits [4*idx+3 : 4*idx]
  - idx advances 0→1→2→3→0; col = ~(4'b0001 << idx)
- Tick with idx==3 ends the scan (scan_done). Candidate is derived from the 16-bit snapshot:
  - all ones → NONE
  - exactly one zero at bit n → KEY(n), where n = 4*col_idx + row_idx
  - two or more zeros → MULTI
- Debounce, evaluated on scan_done only:
  - candidate == previous candidate → stable count increments, saturating at DEBOUNCE_SCANS
  - otherwise → stable count = 1
  - when the count first equals DEBOUNCE_SCANS and candidate != debounced, debounced <= candidate
- Press event only on the debounced transition NONE→KEY(n). No event for MULTI→KEY, KEY→KEY', KEY→NONE, or any transition into MULTI. Holding a key gives exactly one event.
- key_down = (debounced is KEY).
- FIFO:
  - a push writes the code on the cycle after the debounced update; key_present rises 1 cycle after that write
  - read_key_ack while not empty pops the head; ack while empty is ignored
  - push while full and no pop → event dropped, overflow set; overflow clears only on reset
  - push and pop in the same cycle while full → both occur, no overflow
  - push and pop in the same cycle while empty → pop ignored, push occurs
  - pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits
- key_code and key_present are registered, and update the cycle after a push or pop.
- Asserting reset mid-scan or mid-debounce discards all state; queued keys are lost.

Optional Feature:
Macro KEYPAD_ASCII_EN.
- Defined: key_code carries ASCII of the key number: n 0–9 → 8'h30+n, n 10–15 → 8'h41+(n-10), i.e. '0'–'9','A'–'F'. Width and timing are unchanged.
- Undefined: key_code = {4'b0000, n}.
- key_code = 8'h00 when empty in both builds.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, macro undefined.)
- Reset release, no keys held → col cycles 1110,1101,1011,0111 every 4 clks; key_present=0, key_down=0 for 20 scans.
- Drive row[1] low only while col[2] low, held for 3 scans → exactly one push, key_code=8'h09, key_present=1, key_down=1; ack pulse → key_present=0, key_code=8'h00.
- Key 9 bouncing (toggling every scan) for 6 scans, then released → no push; key_down stays 0.
- Keys 0 and 5 held together for 4 scans → debounced MULTI, no push; release key 5 → no push (MULTI→KEY).
- Five separate press/release cycles of keys 1,2,3,4,5 with no ack → FIFO holds 1,2,3,4; overflow=1; four acks return 8'h01..8'h04 in order.
- Rebuild with KEYPAD_ASCII_EN; press key 12 → key_code=8'h43 ('C'). Assert reset mid-debounce of key 3 → all outputs return to reset values and no push follows.
